// File: rtl/upload_arbiter.sv
// Round-robin arbiter merging NUM_SRC upload bundles onto one USB upload channel.
// Grants are held for one burst, capped at MAX_BURST when another source is waiting.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no grant; pick next active source starting at rr_ptr
// S_GRANT | source grant_id owns the channel, ready follows upload_ready
// S_DRAIN | one cycle, ready low, mux held so a late byte still gets out
module upload_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_active,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [8*NUM_SRC-1:0] src_source,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 upload_active,
  output logic                 upload_req,
  output logic                 upload_valid,
  output logic [7:0]           upload_data,
  output logic [7:0]           upload_source,
  input  logic                 upload_ready,
  output logic [2:0]           grant_id,
  output logic                 drop_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [7:0] C_MAX   = 8'(MAX_BURST);
  localparam logic [2:0] C_LAST  = 3'(NUM_SRC - 1);
  localparam logic [3:0] C_NSRC  = 4'(NUM_SRC);

  logic [1:0] r_state;
  logic [2:0] r_rr_ptr;
  logic [2:0] r_grant_id;
  logic [7:0] r_byte_cnt;
  logic       r_drop_err;

  logic                 w_own;
  logic [NUM_SRC-1:0]   w_sel;
  logic                 w_valid_g;
  logic                 w_active_g;
  logic                 w_req_g;
  logic [7:0]           w_data_g;
  logic [7:0]           w_source_g;
  logic                 w_others;
  logic [7:0]           w_cnt_next;
  logic                 w_done;
  logic                 w_limit;
  logic                 w_drop;
  logic [2*NUM_SRC-1:0] w_rot;
  logic [3:0]           w_scan_sum;
  logic [2:0]           w_pick_id;

  assign w_own = (r_state == S_GRANT) || (r_state == S_DRAIN);

  always_comb begin
    w_sel      = '0;
    w_valid_g  = 1'b0;
    w_active_g = 1'b0;
    w_req_g    = 1'b0;
    w_data_g   = '0;
    w_source_g = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_sel[i]   = 1'b1;
        w_valid_g  = src_valid[i];
        w_active_g = src_active[i];
        w_req_g    = src_req[i];
        w_data_g   = src_data[8*i +: 8];
        w_source_g = src_source[8*i +: 8];
      end
    end
  end

  // Rotate so bit 0 is rr_ptr; the lowest set bit after rotation wins.
  assign w_rot = {src_active, src_active} >> r_rr_ptr;

  always_comb begin
    w_pick_id  = '0;
    w_scan_sum = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_scan_sum = {1'b0, r_rr_ptr} + 4'(k);
        if (w_scan_sum >= C_NSRC) w_scan_sum = w_scan_sum - C_NSRC;
        w_pick_id = w_scan_sum[2:0];
      end
    end
  end

  assign w_others   = |(src_active & ~w_sel);
  assign w_cnt_next = (w_valid_g && (r_byte_cnt != C_MAX)) ? r_byte_cnt + 8'd1 : r_byte_cnt;
  assign w_done     = !w_active_g && !w_req_g;
  assign w_limit    = (w_cnt_next == C_MAX) && w_others;
  assign w_drop     = |(src_valid & ~(w_own ? w_sel : '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_byte_cnt <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_drop_err <= w_drop;
      case (r_state)
        S_IDLE: begin
          if (|src_active) begin
            r_grant_id <= w_pick_id;
            r_byte_cnt <= '0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_byte_cnt <= w_cnt_next;
          if (w_done || w_limit) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_rr_ptr <= (r_grant_id == C_LAST) ? 3'd0 : r_grant_id + 3'd1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    upload_active = w_own;
    upload_req    = w_own && w_req_g;
    upload_valid  = w_own && w_valid_g;
    upload_data   = w_own ? w_data_g : 8'd0;
    upload_source = w_own ? w_source_g : 8'd0;
    src_ready     = ((r_state == S_GRANT) && upload_ready) ? w_sel : '0;
    grant_id      = r_grant_id;
    drop_err      = r_drop_err;
  end

endmodule

// File: tb/tb_upload_arbiter.sv
// Directed bench for upload_arbiter: behavioural sources feed the arbiter and a
// negedge monitor records grants, burst lengths and forwarded bytes.
module tb_upload_arbiter;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   src_active;
  logic [N-1:0]   src_req;
  logic [N-1:0]   src_valid;
  logic [8*N-1:0] src_data;
  logic [8*N-1:0] src_source;
  logic [N-1:0]   src_ready;
  logic           upload_active;
  logic           upload_req;
  logic           upload_valid;
  logic [7:0]     upload_data;
  logic [7:0]     upload_source;
  logic           upload_ready;
  logic [2:0]     grant_id;
  logic           drop_err;

  upload_arbiter #(.NUM_SRC(N), .MAX_BURST(64)) dut (
    .clk(clk), .rst(rst),
    .src_active(src_active), .src_req(src_req), .src_valid(src_valid),
    .src_data(src_data), .src_source(src_source), .src_ready(src_ready),
    .upload_active(upload_active), .upload_req(upload_req),
    .upload_valid(upload_valid), .upload_data(upload_data),
    .upload_source(upload_source), .upload_ready(upload_ready),
    .grant_id(grant_id), .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Source model: sends one byte in answer to a ready seen last cycle.
  // Slow sources skip the cycle after each byte, fast ones stream.
  int         rem   [N];
  int         sent  [N];
  logic [7:0] base  [N];
  logic [7:0] sid   [N];
  logic       fast  [N];
  logic       en    [N];
  logic       vprev [N];
  logic [N-1:0] inj;
  logic [N-1:0] glitch;
  logic [N-1:0] rdy_seen;

  // Monitor state
  int         n_grant, n_fwd, n_drop, n_act, n_viol, n_drainfwd;
  int         grant_q [16];
  int         burst_q [16];
  int         nfwd    [N];
  logic       prev_active;
  logic       m_active, m_req, m_valid, m_drop;
  logic [N-1:0] m_ready;
  logic [2:0] m_gid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic v;
      v = en[i] && (rem[i] > 0) && rdy_seen[i] && (fast[i] || !vprev[i]);
      vprev[i] = v;
      src_valid[i] = v | inj[i];
      if (v) begin
        src_data[8*i +: 8] = base[i] + 8'(sent[i]);
        sent[i]++;
        rem[i]--;
      end else if (inj[i]) begin
        src_data[8*i +: 8] = 8'hEE;
      end
      src_source[8*i +: 8] = sid[i];
      src_active[i] = en[i] && (rem[i] > 0) && !glitch[i];
      src_req[i]    = en[i] && (rem[i] > 0);
    end
  endtask

  task automatic step();
    logic [7:0] e_data;
    int g;
    @(negedge clk);
    m_active = upload_active;
    m_req    = upload_req;
    m_valid  = upload_valid;
    m_ready  = src_ready;
    m_gid    = grant_id;
    m_drop   = drop_err;
    if (upload_active && !prev_active && n_grant < 16) begin
      grant_q[n_grant] = int'(grant_id);
      burst_q[n_grant] = 0;
      n_grant++;
    end
    if (upload_valid) begin
      g = int'(grant_id);
      if (n_grant > 0) burst_q[n_grant-1]++;
      if (g < N) begin
        e_data = base[g] + 8'(nfwd[g]);
        check_eq("fwd_byte", {16'd0, upload_source, upload_data}, {16'd0, sid[g], e_data});
        nfwd[g]++;
      end
      n_fwd++;
      if (src_ready == '0 && upload_ready) n_drainfwd++;
    end
    if (drop_err) n_drop++;
    if (upload_active) n_act++;
    if ((src_ready & ~(4'b0001 << grant_id)) != '0) n_viol++;
    prev_active = upload_active;
    rdy_seen    = src_ready;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_stats();
    n_grant = 0; n_fwd = 0; n_drop = 0; n_act = 0; n_viol = 0; n_drainfwd = 0;
    prev_active = 1'b0;
    for (int i = 0; i < N; i++) nfwd[i] = 0;
  endtask

  task automatic start_src(input int i, input int n, input logic [7:0] b,
                           input logic [7:0] s, input logic f);
    en[i] = 1'b1; rem[i] = n; sent[i] = 0; base[i] = b; sid[i] = s;
    fast[i] = f; vprev[i] = 1'b0;
    src_active[i] = 1'b1;
    src_req[i]    = 1'b1;
    src_source[8*i +: 8] = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; rem[i] = 0; sent[i] = 0; vprev[i] = 1'b0;
    end
    inj = '0; glitch = '0; upload_ready = 1'b1;
    steps(2);
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    int eg [8];
    int eb [8];
    int viol;
    int nb0;

    rst = 1'b1; upload_ready = 1'b1;
    src_active = '0; src_req = '0; src_valid = '0; src_data = '0; src_source = '0;
    inj = '0; glitch = '0; rdy_seen = '0;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; rem[i] = 0; sent[i] = 0; base[i] = '0; sid[i] = '0;
      fast[i] = 1'b0; vprev[i] = 1'b0;
    end
    clear_stats();

    // Reset with every source active
    for (int i = 0; i < N; i++) start_src(i, 10, 8'(16*i), 8'(8'h10 + i), 1'b0);
    steps(2);
    check_eq("rst_active", 32'(m_active), 32'd0);
    check_eq("rst_req",    32'(m_req),    32'd0);
    check_eq("rst_valid",  32'(m_valid),  32'd0);
    check_eq("rst_ready",  32'(m_ready),  32'd0);
    check_eq("rst_gid",    32'(m_gid),    32'd0);
    check_eq("rst_drop",   32'(m_drop),   32'd0);
    rst = 1'b0;
    clear_stats();
    step();
    check_eq("arb_cycle_active", 32'(m_active), 32'd0);
    step();
    check_eq("first_grant_active", 32'(m_active), 32'd1);
    check_eq("first_grant_id",     32'(m_gid),    32'd0);

    // Single source, 5 bytes
    do_reset();
    start_src(1, 5, 8'hA0, 8'h14, 1'b0);
    steps(30);
    check_eq("t2_bytes",  32'(n_fwd),   32'd5);
    check_eq("t2_grants", 32'(n_grant), 32'd1);
    check_eq("t2_gid",    32'(grant_q[0]), 32'd1);
    check_eq("t2_active_cycles", 32'(n_act), 32'd11);
    check_eq("t2_drop",   32'(n_drop),  32'd0);

    // Fairness at the burst limit
    do_reset();
    start_src(0, 200, 8'h00, 8'h10, 1'b0);
    start_src(2, 200, 8'h80, 8'h12, 1'b0);
    steps(900);
    eg = '{0, 2, 0, 2, 0, 2, 0, 2};
    eb = '{64, 64, 64, 64, 64, 64, 8, 8};
    check_eq("t3_grants", 32'(n_grant), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check_eq("t3_gid",   32'(grant_q[k]), 32'(eg[k]));
      check_eq("t3_burst", 32'(burst_q[k]), 32'(eb[k]));
    end
    check_eq("t3_bytes", 32'(n_fwd),  32'd400);
    check_eq("t3_drop",  32'(n_drop), 32'd0);

    // Streaming source: the answer to the last ready lands in DRAIN
    do_reset();
    start_src(3, 100, 8'h00, 8'h13, 1'b1);
    steps(10);
    start_src(1, 3, 8'h50, 8'h11, 1'b0);
    steps(200);
    eg = '{3, 1, 3, 0, 0, 0, 0, 0};
    eb = '{65, 3, 35, 0, 0, 0, 0, 0};
    check_eq("t4_grants", 32'(n_grant), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check_eq("t4_gid",   32'(grant_q[k]), 32'(eg[k]));
      check_eq("t4_burst", 32'(burst_q[k]), 32'(eb[k]));
    end
    check_eq("t4_drain_fwd", 32'(n_drainfwd), 32'd1);
    check_eq("t4_bytes", 32'(n_fwd), 32'd103);

    // Protocol error from a source without the grant
    do_reset();
    start_src(0, 6, 8'h30, 8'h10, 1'b0);
    sid[2] = 8'h12;
    steps(5);
    inj = 4'b0100;
    step();
    inj = '0;
    steps(30);
    check_eq("t5_drop_cycles", 32'(n_drop), 32'd1);
    check_eq("t5_bytes",  32'(n_fwd),   32'd6);
    check_eq("t5_grants", 32'(n_grant), 32'd1);

    // Back-pressure, then a one-cycle active glitch with req held
    do_reset();
    start_src(1, 20, 8'h60, 8'h11, 1'b0);
    steps(12);
    upload_ready = 1'b0;
    step();
    nb0 = n_fwd;
    viol = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (m_valid || (m_ready != '0) || !m_active || (m_gid != 3'd1)) viol++;
    end
    check_eq("t6_hold_viol",  32'(viol),  32'd0);
    check_eq("t6_hold_bytes", 32'(n_fwd), 32'(nb0));
    upload_ready = 1'b1;
    steps(4);
    glitch = 4'b0010;
    step();
    glitch = '0;
    steps(60);
    check_eq("t6_grants",   32'(n_grant), 32'd1);
    check_eq("t6_bytes",    32'(n_fwd),   32'd20);
    check_eq("t6_ready_oh", 32'(n_viol),  32'd0);

    // Reset in the middle of a streaming burst
    do_reset();
    start_src(2, 50, 8'h70, 8'h12, 1'b1);
    steps(10);
    rst = 1'b1;
    steps(2);
    check_eq("t7_valid_after_rst",  32'(m_valid),  32'd0);
    check_eq("t7_active_after_rst", 32'(m_active), 32'd0);
    check_eq("t7_ready_after_rst",  32'(m_ready),  32'd0);

    // Solo burst past the cap, then a late competitor
    do_reset();
    start_src(0, 100, 8'h00, 8'h10, 1'b1);
    steps(71);
    start_src(1, 3, 8'h50, 8'h11, 1'b0);
    steps(200);
    eg = '{0, 1, 0, 0, 0, 0, 0, 0};
    eb = '{71, 3, 29, 0, 0, 0, 0, 0};
    check_eq("t8_grants", 32'(n_grant), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check_eq("t8_gid",   32'(grant_q[k]), 32'(eg[k]));
      check_eq("t8_burst", 32'(burst_q[k]), 32'(eb[k]));
    end
    check_eq("t8_drop", 32'(n_drop), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
